// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags -- single-clock FIFO with live fill level, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous
// flush. Storage is an internal register array; read data is registered.
//
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through reads
// (head word presented without a request; i_rd_en pops). Undefined: standard
// mode, where an accepted read presents the word on o_data for one cycle.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_flush                 synchronous clear of contents (memory untouched)
//   i_err_clr               synchronous clear of the sticky error flags
//   i_wr_en, i_data         write request and data
//   i_rd_en                 read request (FWFT: pop)
//   o_data, o_rd_valid      registered read data and its qualifier
//   o_full, o_empty         level == SIZE_DEPTH / level == 0
//   o_almost_full/_empty    level >= AF_LEVEL / level <= AE_LEVEL
//   o_level                 words held, 0..SIZE_DEPTH
//   o_overflow/o_underflow  sticky: write while full / read while empty
module fifo_sync_flags #(
    parameter  int SIZE_DEPTH = 16,
    parameter  int SIZE_DATA  = 8,
    parameter  int AF_LEVEL   = 14,
    parameter  int AE_LEVEL   = 2,
    localparam int SIZE_ADDR  = $clog2(SIZE_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_err_clr,
    input  logic                 i_wr_en,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_rd_en,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [SIZE_ADDR:0]   o_level,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam logic [SIZE_ADDR:0] DEPTH_W = SIZE_DEPTH[SIZE_ADDR:0];
    localparam logic [SIZE_ADDR:0] AF_W    = AF_LEVEL[SIZE_ADDR:0];
    localparam logic [SIZE_ADDR:0] AE_W    = AE_LEVEL[SIZE_ADDR:0];

    logic [SIZE_DATA-1:0] mem_q [SIZE_DEPTH];
    logic [SIZE_ADDR:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [SIZE_DATA-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;

    logic [SIZE_ADDR:0]   mem_cnt, level;
    logic                 full, empty;
    logic                 wr_acc, rd_acc, mem_rd;

    // Pointers carry one extra wrap bit, so the difference is 0..SIZE_DEPTH.
    assign mem_cnt = wptr_q - rptr_q;

`ifdef FIFO_SYNC_FWFT_EN
    // The output register holds a word too; it counts toward level/capacity.
    assign level  = mem_cnt + {{SIZE_ADDR{1'b0}}, valid_q};
    assign rd_acc = i_rd_en & valid_q & ~i_flush;
    // Refill the output stage when it is empty or being popped this edge.
    assign mem_rd = (mem_cnt != '0) & (~valid_q | rd_acc) & ~i_flush;
`else
    assign level  = mem_cnt;
    assign rd_acc = i_rd_en & ~empty & ~i_flush;
    assign mem_rd = rd_acc;
`endif

    assign full   = (level == DEPTH_W);
    assign empty  = (level == '0);
    assign wr_acc = i_wr_en & ~full & ~i_flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        // Set beats clear; flush neither sets nor clears the error flags.
        ovf_d   = (ovf_q & ~i_err_clr) | (i_wr_en & full  & ~i_flush);
        udf_d   = (udf_q & ~i_err_clr) | (i_rd_en & empty & ~i_flush);
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (mem_rd) begin
                rptr_d = rptr_q + 1'b1;
                data_d = mem_q[rptr_q[SIZE_ADDR-1:0]];
            end
`ifdef FIFO_SYNC_FWFT_EN
            valid_d = mem_rd | (valid_q & ~rd_acc);
`else
            valid_d = rd_acc;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array has no reset; contents are qualified by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wptr_q[SIZE_ADDR-1:0]] <= i_data;
    end

    assign o_data         = data_q;
    assign o_rd_valid     = valid_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (level >= AF_W);
    assign o_almost_empty = (level <= AE_W);
    assign o_level        = level;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, err_clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rd_valid, full, empty, afull, aempty, ovf, udf;
    logic [4:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_sync_flags #(.SIZE_DEPTH(16), .SIZE_DATA(8), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_err_clr(err_clr),
        .i_wr_en(wr_en), .i_data(wdata), .i_rd_en(rd_en),
        .o_data(rdata), .o_rd_valid(rd_valid), .o_full(full), .o_empty(empty),
        .o_almost_full(afull), .o_almost_empty(aempty), .o_level(level),
        .o_overflow(ovf), .o_underflow(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; applies inputs across the next edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic ec);
        wr_en = wr; wdata = d; rd_en = rd; flush = fl; err_clr = ec;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " data"},   rdata,    0);
        chk({tag, " rdv"},    rd_valid, 0);
        chk({tag, " level"},  level,    0);
        chk({tag, " empty"},  empty,    1);
        chk({tag, " full"},   full,     0);
        chk({tag, " ae"},     aempty,   1);
        chk({tag, " af"},     afull,    0);
        chk({tag, " ovf"},    ovf,      0);
        chk({tag, " udf"},    udf,      0);
    endtask

    typedef struct {
        int         rep;
        logic       wr, rd, fl, ec;
        logic [7:0] d;
        int         lvl;
        logic       af, ae, emp, ful, rdv, ovf, udf;
    } vec_t;

    vec_t tbl[17];
    logic [7:0] q[$];
    logic [7:0] exp_d, rnd;

    initial begin
        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef FIFO_SYNC_FWFT_EN
        // Write into empty: visible on the output one edge later, no request.
        step(1, 8'h3C, 0, 0, 0);
        chk("fwft wr lvl", level, 1);
        chk("fwft wr rdv", rd_valid, 0);
        chk("fwft wr empty", empty, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("fwft head rdv", rd_valid, 1);
        chk("fwft head data", rdata, 8'h3C);
        chk("fwft head lvl", level, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft pop rdv", rd_valid, 0);
        chk("fwft pop empty", empty, 1);
        chk("fwft pop lvl", level, 0);
        // Order through the output stage.
        step(1, 8'hB1, 0, 0, 0);
        step(1, 8'hB2, 0, 0, 0);
        step(1, 8'hB3, 0, 0, 0);
        chk("fwft b lvl", level, 3);
        chk("fwft b head", rdata, 8'hB1);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft b2", rdata, 8'hB2);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft b3", rdata, 8'hB3);
        chk("fwft b3 rdv", rd_valid, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft b end rdv", rd_valid, 0);
        chk("fwft b end empty", empty, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft udf", udf, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("fwft udf clr", udf, 0);
        // Capacity includes the output word.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        chk("fwft full lvl", level, 16);
        chk("fwft full", full, 1);
        chk("fwft full head", rdata, 8'h40);
        step(1, 8'hEE, 0, 0, 0);
        chk("fwft ovf", ovf, 1);
        chk("fwft ovf lvl", level, 16);
        step(0, 8'h00, 0, 1, 1);
        chk("fwft flush lvl", level, 0);
        chk("fwft flush rdv", rd_valid, 0);
        // Async reset in the middle of a burst.
        step(1, 8'h61, 0, 0, 0);
        step(1, 8'h62, 0, 0, 0);
        step(1, 8'h63, 1, 0, 0);
        wr_en = 1'b1; wdata = 8'h64;
        #2 rst_n = 1'b0;
        #1 chk_reset("fwft async");
        wr_en = 1'b0;
`else
        // Fill 0x01..0x10, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            chk($sformatf("fill lvl %0d", i), level, i);
        end
        chk("fill full", full, 1);
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk($sformatf("drain data %0d", i), rdata, i);
            chk($sformatf("drain rdv %0d", i), rd_valid, 1);
            chk($sformatf("drain lvl %0d", i), level, 16 - i);
        end
        chk("drain empty", empty, 1);
        step(0, 8'h00, 0, 0, 0);
        chk("idle rdv", rd_valid, 0);
        chk("idle data hold", rdata, 8'h10);

        // Full + write + read: read wins, write dropped.
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        chk("ovf rd data", rdata, 8'h01);
        chk("ovf rd rdv", rd_valid, 1);
        chk("ovf flag", ovf, 1);
        chk("ovf lvl", level, 15);
        step(0, 8'h00, 0, 0, 1);
        chk("ovf clr", ovf, 0);
        chk("ovf clr lvl", level, 15);
        for (int i = 2; i <= 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk($sformatf("ovf drain %0d", i), rdata, i);
        end
        chk("ovf drain empty", empty, 1);

        // Empty + write + read: write wins, read rejected.
        step(1, 8'h55, 1, 0, 0);
        chk("udf flag", udf, 1);
        chk("udf lvl", level, 1);
        chk("udf rdv", rd_valid, 0);
        chk("udf data hold", rdata, 8'h10);
        step(0, 8'h00, 1, 0, 1);
        chk("udf rd data", rdata, 8'h55);
        chk("udf cleared", udf, 0);
        chk("udf rd lvl", level, 0);

        // Continuous write+read at level 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            rnd = 8'($urandom);
            q.push_back(rnd);
            step(1, rnd, 0, 0, 0);
        end
        chk("stream lvl pre", level, 5);
        for (int i = 0; i < 40; i++) begin
            rnd = 8'($urandom);
            exp_d = q.pop_front();
            q.push_back(rnd);
            step(1, rnd, 1, 0, 0);
            chk($sformatf("stream data %0d", i), rdata, exp_d);
            chk($sformatf("stream lvl %0d", i), level, 5);
        end
        for (int i = 0; i < 5; i++) begin
            exp_d = q.pop_front();
            step(0, 8'h00, 1, 0, 0);
            chk($sformatf("stream tail %0d", i), rdata, exp_d);
        end
        chk("stream end empty", empty, 1);

        // Thresholds, flush, error-flag corners.
        //           rep wr rd fl ec data   lvl af ae em fu rv ov ud
        tbl[0]  = '{12, 1, 0, 0, 0, 8'h21, 12, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{ 1, 1, 0, 0, 0, 8'h22, 13, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{ 1, 1, 0, 0, 0, 8'h23, 14, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{ 1, 0, 1, 0, 0, 8'h00, 13, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{10, 0, 1, 0, 0, 8'h00,  3, 0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{ 1, 0, 1, 0, 0, 8'h00,  2, 0, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{ 1, 0, 1, 0, 0, 8'h00,  1, 0, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{ 8, 1, 0, 0, 0, 8'h31,  9, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{ 1, 1, 1, 1, 0, 8'h32,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{ 1, 0, 1, 0, 0, 8'h00,  0, 0, 1, 1, 0, 0, 0, 1};
        tbl[10] = '{ 1, 0, 1, 0, 1, 8'h00,  0, 0, 1, 1, 0, 0, 0, 1};
        tbl[11] = '{ 1, 0, 0, 0, 1, 8'h00,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{16, 1, 0, 0, 0, 8'h41, 16, 1, 0, 0, 1, 0, 0, 0};
        tbl[13] = '{ 1, 1, 0, 0, 0, 8'h42, 16, 1, 0, 0, 1, 0, 1, 0};
        tbl[14] = '{ 1, 1, 0, 0, 1, 8'h43, 16, 1, 0, 0, 1, 0, 1, 0};
        tbl[15] = '{ 1, 0, 0, 1, 0, 8'h00,  0, 0, 1, 1, 0, 0, 1, 0};
        tbl[16] = '{ 1, 0, 0, 0, 1, 8'h00,  0, 0, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].ec);
            chk($sformatf("vec%0d lvl", i),   level,    tbl[i].lvl);
            chk($sformatf("vec%0d af", i),    afull,    tbl[i].af);
            chk($sformatf("vec%0d ae", i),    aempty,   tbl[i].ae);
            chk($sformatf("vec%0d empty", i), empty,    tbl[i].emp);
            chk($sformatf("vec%0d full", i),  full,     tbl[i].ful);
            chk($sformatf("vec%0d rdv", i),   rd_valid, tbl[i].rdv);
            chk($sformatf("vec%0d ovf", i),   ovf,      tbl[i].ovf);
            chk($sformatf("vec%0d udf", i),   udf,      tbl[i].udf);
        end

        // Async reset mid-operation, no clock edge needed.
        step(1, 8'h71, 0, 0, 0);
        step(1, 8'h72, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("pre-rst data", rdata, 8'h71);
        wr_en = 1'b1; wdata = 8'h73;
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        wr_en = 1'b0;
`endif
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst lvl", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised successor to the team's single-clock synchronous FIFO: power-of-two depth, arbitrary data width, registered read data, and a live fill level with static almost-full/almost-empty thresholds. Adds sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. Sits between any single-clock producer/consumer pair in the datapath. Storage is an inferred register array internal to the block.

## Interface
- SIZE_DEPTH, 16, number of words; power of two, ≥2
- SIZE_DATA, 8, data width in bits
- AF_LEVEL, 14, `o_almost_full` asserts when level ≥ AF_LEVEL; 1..SIZE_DEPTH
- AE_LEVEL, 2, `o_almost_empty` asserts when level ≤ AE_LEVEL; 0..SIZE_DEPTH-1
- SIZE_ADDR, $clog2(SIZE_DEPTH), derived; do not override

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_flush  in  1  synchronous clear of contents
- i_err_clr  in  1  synchronous clear of sticky error flags
- i_wr_en  in  1  write request
- i_data  in  SIZE_DATA  write data
- i_rd_en  in  1  read request (FWFT: pop/acknowledge)
- o_data  out  SIZE_DATA  read data, registered
- o_rd_valid  out  1  standard: read data presented this cycle; FWFT: o_data holds the head word
- o_full  out  1  level == SIZE_DEPTH
- o_empty  out  1  level == 0
- o_almost_full  out  1  level ≥ AF_LEVEL
- o_almost_empty  out  1  level ≤ AE_LEVEL
- o_level  out  SIZE_ADDR+1  words stored, 0..SIZE_DEPTH
- o_overflow  out  1  sticky: write attempted while full
- o_underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted iff `i_wr_en & ~o_full & ~i_flush`; read accepted iff `i_rd_en & ~o_empty & ~i_flush`.
- Pointers SIZE_ADDR+1 bits, wrap modulo 2·SIZE_DEPTH; MSB differs and low bits equal ⇒ full, equal ⇒ empty.
- Level: +1 on write-only, −1 on read-only, unchanged on both or neither. Full + write + read: read accepted, write rejected (overflow set). Empty + write + read: write accepted, read rejected (underflow set).
- Rejected writes never alter memory or pointers; rejected reads never alter o_data.
- Overflow/underflow set on rejected request edge; hold until i_err_clr or reset. Set and clear same edge: set wins.
- Flush: pointers, level → 0, o_rd_valid → 0; requests that cycle ignored, do not set error flags; memory contents unchanged; o_data holds.
- Flags combinational from registered pointers/level only; no combinational path from i_wr_en/i_rd_en to any output.

## Timing
- Reset values: o_data 0, o_rd_valid 0, o_level 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0 (unless AF_LEVEL ≤ 0, illegal), o_overflow 0, o_underflow 0.
- Standard mode: read accepted at edge N ⇒ o_data = head word and o_rd_valid = 1 from edge N for one cycle; o_data holds afterwards.
- Write at edge N visible in o_level/flags from edge N; readable from edge N+1.
- Back-to-back reads at full rate sustained; one read and one write per cycle.
- Reset mid-operation: all state to reset values immediately, no clock required.

## Configuration
- FIFO_SYNC_FWFT_EN defined: FWFT mode. Head word presented on o_data with o_rd_valid = 1 without request; i_rd_en with o_rd_valid pops, next word (or o_rd_valid = 0) from that edge. Write into empty FIFO at edge N ⇒ o_rd_valid = 1, o_data = written word from edge N+1. Output stage counts in o_level; capacity remains SIZE_DEPTH.
- Undefined: standard mode as above.

## Test plan
- Reset, write 0x01..0x10 (16 words), read 16 -> data 0x01..0x10 in order, o_full 1 after 16th write, o_empty 1 after 16th read, o_level 16→0.
- Fill to 16, write 0xAA with simultaneous read -> read returns 0x01, 0xAA dropped, o_overflow 1, level stays 15; i_err_clr -> o_overflow 0.
- Empty, read with simultaneous write 0x55 -> o_underflow 1, level 1, next read returns 0x55.
- 40 cycles continuous write+read with random data, level held at 5 -> order preserved across pointer wrap, level constant 5.
- Write 13, 14, 3, 2 words levels -> o_almost_full at level 14 not 13; o_almost_empty at level 2 not 3; flush at level 9 -> level 0, o_empty 1, no error flag.
- FWFT build: write 0x3C to empty -> o_rd_valid 1, o_data 0x3C next cycle without i_rd_en; assert i_rd_en -> o_rd_valid 0, o_empty 1; async reset mid-burst -> all outputs reset values.
